// File: rtl/nf10_axil_ipif_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nf10_axil_ipif_bridge
// Purpose  : AXI4-Lite slave to single-BAR IPIF bridge. Accepts one AXI
//            transaction at a time, decodes it against the BAR window, drives
//            the Bus2IP_* strobes until the IP acknowledges, then returns the
//            AXI read or write response.
// Ports    : S_AXI_ACLK / S_AXI_ARESET   clock, async active-high reset
//            S_AXI_AW* / S_AXI_W* / S_AXI_B*   AXI4-Lite write channels
//            S_AXI_AR* / S_AXI_R*          AXI4-Lite read channels
//            Bus2IP_Addr/CS/RNW/Data/BE    IPIF request (registered)
//            IP2Bus_Data/RdAck/WrAck/Error IPIF completion
// Options  : `define NF10_AXIL_IPIF_TIMEOUT_EN to add a data-phase timeout of
//            C_DPHASE_TIMEOUT CS cycles (0 disables it). Without the macro the
//            bridge waits indefinitely for an acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module nf10_axil_ipif_bridge #(
    parameter int                              C_S_AXI_DATA_WIDTH = 32,
    parameter int                              C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_BASEADDR         = {C_S_AXI_ADDR_WIDTH{1'b1}},
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_HIGHADDR         = '0,
    parameter int                              C_DPHASE_TIMEOUT   = 16
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]       Bus2IP_Addr,
    output logic                                Bus2IP_CS,
    output logic                                Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]     Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       IP2Bus_Data,
    input  logic                                IP2Bus_RdAck,
    input  logic                                IP2Bus_WrAck,
    input  logic                                IP2Bus_Error
);

    localparam int         c_sw           = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_rd_wait   = 3'd1;
    localparam logic [2:0] c_st_wr_wait   = 3'd2;
    localparam logic [2:0] c_st_r_resp    = 3'd3;
    localparam logic [2:0] c_st_b_resp    = 3'd4;
    localparam logic [1:0] c_resp_okay    = 2'b00;
    localparam logic [1:0] c_resp_slverr  = 2'b10;
    localparam logic [1:0] c_resp_decerr  = 2'b11;

    logic [2:0]                     r_state;
    logic [2:0]                     w_state_nxt;
    logic                           r_last_wr;
    logic [C_S_AXI_ADDR_WIDTH-1:0]  r_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_wdata;
    logic [c_sw-1:0]                r_be;
    logic                           r_rnw;
    logic                           r_cs;
    logic [C_S_AXI_DATA_WIDTH-1:0]  r_rdata;
    logic [1:0]                     r_rresp;
    logic [1:0]                     r_bresp;
    logic                           r_rvalid;
    logic                           r_bvalid;

    logic w_rd_cand, w_wr_cand, w_grant_rd, w_grant_wr;
    logic w_acc_rd, w_acc_wr, w_rd_ack, w_wr_ack, w_tmo;
    logic w_hit_ar, w_hit_aw;

    // A write is only a candidate once address and data are both present, so
    // a write is never split across cycles. Reset blocks any accept so READY
    // stays low while reset is asserted.
    assign w_rd_cand  = S_AXI_ARVALID && !S_AXI_ARESET;
    assign w_wr_cand  = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_ARESET;
    assign w_grant_rd = w_rd_cand && (!w_wr_cand || r_last_wr);
    assign w_grant_wr = w_wr_cand && !w_grant_rd;

    // Inclusive BAR window; base above high yields no hits at all.
    assign w_hit_ar = (S_AXI_ARADDR >= C_BASEADDR) && (S_AXI_ARADDR <= C_HIGHADDR);
    assign w_hit_aw = (S_AXI_AWADDR >= C_BASEADDR) && (S_AXI_AWADDR <= C_HIGHADDR);

`ifdef NF10_AXIL_IPIF_TIMEOUT_EN
    localparam logic [31:0] c_tmo_last = 32'(C_DPHASE_TIMEOUT) - 32'd1;
    logic [31:0] r_tcnt;

    // Counts CS-high cycles; cleared on accept, which is the cycle before CS rises.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_tcnt <= '0;
        end else if (w_acc_rd || w_acc_wr) begin
            r_tcnt <= '0;
        end else if (r_cs) begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end

    assign w_tmo = (C_DPHASE_TIMEOUT != 0) && r_cs && (r_tcnt == c_tmo_last);
`else
    assign w_tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_acc_rd    = 1'b0;
        w_acc_wr    = 1'b0;
        w_rd_ack    = 1'b0;
        w_wr_ack    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_grant_rd) begin
                    w_acc_rd    = 1'b1;
                    w_state_nxt = w_hit_ar ? c_st_rd_wait : c_st_r_resp;
                end else if (w_grant_wr) begin
                    w_acc_wr    = 1'b1;
                    w_state_nxt = w_hit_aw ? c_st_wr_wait : c_st_b_resp;
                end
            end
            c_st_rd_wait: begin
                // An acknowledge in the expiry cycle takes precedence over the timeout.
                if (r_cs && IP2Bus_RdAck) begin
                    w_rd_ack    = 1'b1;
                    w_state_nxt = c_st_r_resp;
                end else if (w_tmo) begin
                    w_state_nxt = c_st_r_resp;
                end
            end
            c_st_wr_wait: begin
                if (r_cs && IP2Bus_WrAck) begin
                    w_wr_ack    = 1'b1;
                    w_state_nxt = c_st_b_resp;
                end else if (w_tmo) begin
                    w_state_nxt = c_st_b_resp;
                end
            end
            c_st_r_resp: begin
                if (r_rvalid && S_AXI_RREADY) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_b_resp: begin
                if (r_bvalid && S_AXI_BREADY) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Request/response datapath
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_last_wr <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_rnw     <= 1'b1;
            r_cs      <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
            r_bresp   <= c_resp_okay;
            r_rvalid  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            if (w_acc_rd) begin
                r_last_wr <= 1'b0;
                r_addr    <= S_AXI_ARADDR;
                r_be      <= '1;
                r_rnw     <= 1'b1;
                r_cs      <= w_hit_ar;
                if (!w_hit_ar) begin
                    r_rdata <= '0;
                    r_rresp <= c_resp_decerr;
                end
            end
            if (w_acc_wr) begin
                r_last_wr <= 1'b1;
                r_addr    <= S_AXI_AWADDR;
                r_wdata   <= S_AXI_WDATA;
                r_be      <= S_AXI_WSTRB;
                r_rnw     <= 1'b0;
                r_cs      <= w_hit_aw;
                if (!w_hit_aw) begin
                    r_bresp <= c_resp_decerr;
                end
            end
            if (w_rd_ack) begin
                r_cs    <= 1'b0;
                r_rdata <= IP2Bus_Data;
                r_rresp <= IP2Bus_Error ? c_resp_slverr : c_resp_okay;
            end else if (r_state == c_st_rd_wait && w_tmo) begin
                r_cs    <= 1'b0;
                r_rdata <= '0;
                r_rresp <= c_resp_slverr;
            end
            if (w_wr_ack) begin
                r_cs    <= 1'b0;
                r_bresp <= IP2Bus_Error ? c_resp_slverr : c_resp_okay;
            end else if (r_state == c_st_wr_wait && w_tmo) begin
                r_cs    <= 1'b0;
                r_bresp <= c_resp_slverr;
            end
            // VALID rises one cycle after entering the response state, giving
            // three cycles from accept to RVALID with a zero-wait IP.
            if (r_state == c_st_r_resp && !r_rvalid) begin
                r_rvalid <= 1'b1;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
            if (r_state == c_st_b_resp && !r_bvalid) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = w_acc_rd;
    assign S_AXI_AWREADY = w_acc_wr;
    assign S_AXI_WREADY  = w_acc_wr;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BVALID  = r_bvalid;
    assign Bus2IP_Addr   = r_addr;
    assign Bus2IP_CS     = r_cs;
    assign Bus2IP_RNW    = r_rnw;
    assign Bus2IP_Data   = r_wdata;
    assign Bus2IP_BE     = r_be;

endmodule
`default_nettype wire

// File: tb/tb_nf10_axil_ipif_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nf10_axil_ipif_bridge
// Purpose  : Self-checking bench for nf10_axil_ipif_bridge. A behavioural IP
//            responder answers CS requests; a word-addressed memory model
//            predicts read data and responses from the BAR/error rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nf10_axil_ipif_bridge;

    localparam logic [31:0] c_base = 32'h7A00_0000;
    localparam logic [31:0] c_high = 32'h7A00_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] Bus2IP_Addr;
    logic        Bus2IP_CS;
    logic        Bus2IP_RNW;
    logic [31:0] Bus2IP_Data;
    logic [3:0]  Bus2IP_BE;
    logic [31:0] IP2Bus_Data = '0;
    logic        IP2Bus_RdAck = 1'b0;
    logic        IP2Bus_WrAck = 1'b0;
    logic        IP2Bus_Error = 1'b0;

    always #5 clk = ~clk;

    nf10_axil_ipif_bridge #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_BASEADDR         (c_base),
        .C_HIGHADDR         (c_high),
        .C_DPHASE_TIMEOUT   (8)
    ) u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .Bus2IP_Addr   (Bus2IP_Addr),
        .Bus2IP_CS     (Bus2IP_CS),
        .Bus2IP_RNW    (Bus2IP_RNW),
        .Bus2IP_Data   (Bus2IP_Data),
        .Bus2IP_BE     (Bus2IP_BE),
        .IP2Bus_Data   (IP2Bus_Data),
        .IP2Bus_RdAck  (IP2Bus_RdAck),
        .IP2Bus_WrAck  (IP2Bus_WrAck),
        .IP2Bus_Error  (IP2Bus_Error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_mem [logic [31:0]];
    logic [31:0] ip_mem  [logic [31:0]];

    function automatic bit in_bar(input logic [31:0] a);
        return (a >= c_base) && (a <= c_high);
    endfunction

    // The IP flags an error for any address in the 0x...E000-0x...EFFF page.
    function automatic bit ip_err(input logic [31:0] a);
        return a[15:12] == 4'hE;
    endfunction

    function automatic logic [31:0] exp_get(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return exp_mem.exists(k) ? exp_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] ip_get(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return ip_mem.exists(k) ? ip_mem[k] : 32'h0;
    endfunction

    function automatic void exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = exp_get(a);
        for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        exp_mem[{a[31:2], 2'b00}] = cur;
    endfunction

    // ---------------- behavioural IP responder ----------------
    int          ip_wait  = 0;
    bit          ip_noack = 1'b0;
    bit          ip_wrong = 1'b0;
    int          ip_cnt   = 0;
    bit          ip_done  = 1'b0;
    int          cs_rises = 0;
    int          cs_cycles = 0;
    logic        cs_prev  = 1'b0;
    logic [31:0] snap_addr = '0;
    logic [31:0] snap_data = '0;
    logic [3:0]  snap_be   = '0;
    logic        snap_rnw  = 1'b0;

    always @(negedge clk) begin
        logic [31:0] cur;
        IP2Bus_RdAck = 1'b0;
        IP2Bus_WrAck = 1'b0;
        IP2Bus_Error = 1'b0;
        IP2Bus_Data  = $urandom;
        if (Bus2IP_CS && !cs_prev) cs_rises++;
        cs_prev = Bus2IP_CS;
        if (!Bus2IP_CS) begin
            ip_cnt  = 0;
            ip_done = 1'b0;
        end else begin
            cs_cycles++;
            if (!ip_done && !ip_noack) begin
                if (ip_cnt == ip_wait) begin
                    ip_done   = 1'b1;
                    snap_addr = Bus2IP_Addr;
                    snap_data = Bus2IP_Data;
                    snap_be   = Bus2IP_BE;
                    snap_rnw  = Bus2IP_RNW;
                    IP2Bus_Error = ip_err(Bus2IP_Addr);
                    if (Bus2IP_RNW) begin
                        IP2Bus_RdAck = 1'b1;
                        IP2Bus_Data  = ip_get(Bus2IP_Addr);
                    end else begin
                        IP2Bus_WrAck = 1'b1;
                        if (!IP2Bus_Error) begin
                            cur = ip_get(Bus2IP_Addr);
                            for (int b = 0; b < 4; b++)
                                if (Bus2IP_BE[b]) cur[8*b +: 8] = Bus2IP_Data[8*b +: 8];
                            ip_mem[{Bus2IP_Addr[31:2], 2'b00}] = cur;
                        end
                    end
                end else begin
                    // Opposite-type acknowledge with error, which the bridge must ignore.
                    if (ip_wrong) begin
                        IP2Bus_Error = 1'b1;
                        if (Bus2IP_RNW) IP2Bus_WrAck = 1'b1;
                        else            IP2Bus_RdAck = 1'b1;
                    end
                    ip_cnt++;
                end
            end
        end
    end

    // ---------------- transaction tasks ----------------
    task automatic issue_read(input logic [31:0] a);
        int g;
        @(negedge clk);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        #1;
        g = 0;
        while (!S_AXI_ARREADY && g < 50) begin @(negedge clk); #1; g++; end
        chk1("arready", S_AXI_ARREADY, 1'b1);
        @(posedge clk);
        #1 S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_r(input logic [31:0] ed, input logic [1:0] er, input int hold, output int lat);
        int g;
        g   = 0;
        lat = 1;
        @(negedge clk);
        while (!S_AXI_RVALID && g < 100) begin @(posedge clk); lat++; @(negedge clk); g++; end
        chk1("rvalid_seen", S_AXI_RVALID, 1'b1);
        chk("rdata", S_AXI_RDATA, ed);
        chk("rresp", {30'b0, S_AXI_RRESP}, {30'b0, er});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk1("rvalid_hold", S_AXI_RVALID, 1'b1);
            chk("rdata_hold", S_AXI_RDATA, ed);
            chk("rresp_hold", {30'b0, S_AXI_RRESP}, {30'b0, er});
        end
        S_AXI_RREADY = 1'b1;
        @(posedge clk);
        #1 S_AXI_RREADY = 1'b0;
        @(negedge clk);
        chk1("rvalid_clear", S_AXI_RVALID, 1'b0);
    endtask

    task automatic wait_b(input logic [1:0] er, input int hold);
        int g;
        g = 0;
        @(negedge clk);
        while (!S_AXI_BVALID && g < 100) begin @(negedge clk); g++; end
        chk1("bvalid_seen", S_AXI_BVALID, 1'b1);
        chk("bresp", {30'b0, S_AXI_BRESP}, {30'b0, er});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bresp_hold", {30'b0, S_AXI_BRESP}, {30'b0, er});
        end
        S_AXI_BREADY = 1'b1;
        @(posedge clk);
        #1 S_AXI_BREADY = 1'b0;
        @(negedge clk);
        chk1("bvalid_clear", S_AXI_BVALID, 1'b0);
    endtask

    task automatic read_txn(input logic [31:0] a, input int w, input int hold, input bit chk_lat);
        logic [31:0] ed;
        logic [1:0]  er;
        int r0, lat;
        ip_wait = w;
        r0 = cs_rises;
        ed = in_bar(a) ? exp_get(a) : 32'h0;
        er = !in_bar(a) ? 2'b11 : (ip_err(a) ? 2'b10 : 2'b00);
        issue_read(a);
        wait_r(ed, er, hold, lat);
        if (chk_lat) chk("rd_latency", lat, 32'd3);
        chk("rd_cs_rises", cs_rises - r0, in_bar(a) ? 32'd1 : 32'd0);
        if (in_bar(a)) begin
            chk("rd_ip_addr", snap_addr, a);
            chk("rd_ip_be", {28'b0, snap_be}, 32'hF);
            chk1("rd_ip_rnw", snap_rnw, 1'b1);
        end
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int w, input int hold);
        logic [1:0] er;
        int r0, g;
        ip_wait = w;
        r0 = cs_rises;
        @(negedge clk);
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < lead; i++) begin
            #1;
            chk1("aw_alone_no_accept", S_AXI_AWREADY | S_AXI_WREADY, 1'b0);
            @(negedge clk);
        end
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        S_AXI_WVALID = 1'b1;
        #1;
        g = 0;
        while (!S_AXI_AWREADY && g < 50) begin @(negedge clk); #1; g++; end
        chk1("awready", S_AXI_AWREADY, 1'b1);
        chk1("wready", S_AXI_WREADY, 1'b1);
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        er = !in_bar(a) ? 2'b11 : (ip_err(a) ? 2'b10 : 2'b00);
        if (in_bar(a) && !ip_err(a)) exp_wr(a, d, s);
        wait_b(er, hold);
        chk("wr_cs_rises", cs_rises - r0, in_bar(a) ? 32'd1 : 32'd0);
        if (in_bar(a)) begin
            chk("wr_ip_addr", snap_addr, a);
            chk("wr_ip_data", snap_data, d);
            chk("wr_ip_be", {28'b0, snap_be}, {28'b0, s});
            chk1("wr_ip_rnw", snap_rnw, 1'b0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat, g, n;
        bit is_rd;
        logic [31:0] a;

        // Reset state, with a read request pending that must not be accepted.
        S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        chk1("rst_arready", S_AXI_ARREADY, 1'b0);
        chk1("rst_awready", S_AXI_AWREADY, 1'b0);
        chk1("rst_rvalid", S_AXI_RVALID, 1'b0);
        chk1("rst_bvalid", S_AXI_BVALID, 1'b0);
        chk1("rst_cs", Bus2IP_CS, 1'b0);
        chk1("rst_rnw", Bus2IP_RNW, 1'b1);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_resp", {28'b0, S_AXI_RRESP, S_AXI_BRESP}, 32'h0);
        chk("rst_addr", Bus2IP_Addr, 32'h0);
        chk("rst_data", Bus2IP_Data, 32'h0);
        chk("rst_be", {28'b0, Bus2IP_BE}, 32'h0);
        S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait read of a known value.
        ip_mem[32'h7A00_0004]  = 32'h2013_0415;
        exp_mem[32'h7A00_0004] = 32'h2013_0415;
        read_txn(32'h7A00_0004, 0, 0, 1'b1);

        // Write with AWVALID leading WVALID by two cycles, then read it back.
        write_txn(32'h7A00_0000, 32'hDEAD_BEEF, 4'h3, 2, 0, 0);
        read_txn(32'h7A00_0000, 1, 1, 1'b0);

        // Decode misses.
        read_txn(32'h1000_0000, 0, 0, 1'b0);
        write_txn(32'h1000_0000, 32'h1234_5678, 4'hF, 0, 0, 1);

        // Simultaneous read/write requests held across four transactions.
        exp_mem[32'h7A00_0010] = 32'hCAFE_0010;
        ip_mem[32'h7A00_0010]  = 32'hCAFE_0010;
        ip_wait = 0;
        @(negedge clk);
        S_AXI_ARADDR  = c_base + 32'h10;
        S_AXI_AWADDR  = c_base + 32'h20;
        S_AXI_WDATA   = 32'hA5A5_0001;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            g = 0;
            while (!(S_AXI_ARREADY || S_AXI_AWREADY) && g < 50) begin @(negedge clk); #1; g++; end
            chk1("arb_order", S_AXI_ARREADY, (k % 2) == 0);
            chk1("arb_exclusive", S_AXI_ARREADY & S_AXI_AWREADY, 1'b0);
            is_rd = S_AXI_ARREADY;
            @(posedge clk);
            #1;
            if (k == 2) S_AXI_ARVALID = 1'b0;
            if (k == 3) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
            if (is_rd) begin
                wait_r(exp_get(c_base + 32'h10), 2'b00, (k == 0) ? 5 : 0, lat);
            end else begin
                exp_wr(c_base + 32'h20, 32'hA5A5_0001, 4'hF);
                wait_b(2'b00, 0);
            end
        end
        read_txn(c_base + 32'h20, 0, 0, 1'b0);

        // IP error responses.
        read_txn(32'h7A00_E000, 0, 0, 1'b0);
        write_txn(32'h7A00_E004, 32'h0BAD_F00D, 4'hF, 0, 2, 0);

        // Wrong-type acknowledges before the real one are ignored.
        ip_wrong = 1'b1;
        read_txn(32'h7A00_0000, 2, 0, 1'b0);
        write_txn(32'h7A00_0100, 32'h5555_AAAA, 4'hC, 1, 2, 0);
        ip_wrong = 1'b0;

`ifdef NF10_AXIL_IPIF_TIMEOUT_EN
        // Silent IP: CS must drop after exactly 8 cycles with SLVERR and zero data.
        ip_noack = 1'b1;
        n = cs_cycles;
        issue_read(c_base + 32'h44);
        wait_r(32'h0, 2'b10, 0, lat);
        chk("tmo_cs_cycles", cs_cycles - n, 32'd8);
        ip_noack = 1'b0;
`endif

        // Reset in the middle of a transaction drops it.
        ip_wait = 8;
        issue_read(c_base + 32'h40);
        @(negedge clk);
        chk1("mid_cs_before_rst", Bus2IP_CS, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("mid_rst_cs", Bus2IP_CS, 1'b0);
        chk1("mid_rst_rnw", Bus2IP_RNW, 1'b1);
        chk("mid_rst_addr", Bus2IP_Addr, 32'h0);
        chk1("mid_rst_rvalid", S_AXI_RVALID, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ip_wait = 0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (S_AXI_RVALID || Bus2IP_CS) n++;
        end
        chk("mid_rst_no_response", n, 32'd0);

        // BAR boundaries.
        read_txn(c_base, 0, 0, 1'b0);
        read_txn(c_high, 0, 0, 1'b0);
        read_txn(c_high + 32'd1, 0, 0, 1'b0);
        read_txn(c_base - 32'd1, 0, 0, 1'b0);

        // Randomized mix against the reference model.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = c_base + (32'($urandom_range(0, 31)) << 2);
                3:       a = c_base + 32'hE000 + (32'($urandom_range(0, 15)) << 2);
                4:       a = c_high + 32'd1 + (32'($urandom_range(0, 255)) << 2);
                default: a = $urandom & 32'h79FF_FFFF;
            endcase
            ip_wrong = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                read_txn(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            else
                write_txn(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end
        ip_wrong = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
